// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide sequencer.
// Funct codes, ALU operation codes, result-mux selects and sequencer states.
package alu_ctl_pkg;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;

  localparam logic [5:0] F_sll  = 6'd0;
  localparam logic [5:0] F_mfhi = 6'd16;
  localparam logic [5:0] F_mflo = 6'd18;
  localparam logic [5:0] F_mult = 6'd25;
  localparam logic [5:0] F_div  = 6'd27;
  localparam logic [5:0] F_add  = 6'd32;
  localparam logic [5:0] F_sub  = 6'd34;
  localparam logic [5:0] F_and  = 6'd36;
  localparam logic [5:0] F_or   = 6'd37;
  localparam logic [5:0] F_slt  = 6'd42;

  localparam logic [2:0] ALU_and  = 3'b000;
  localparam logic [2:0] ALU_or   = 3'b001;
  localparam logic [2:0] ALU_add  = 3'b010;
  localparam logic [2:0] ALU_sll  = 3'b011;
  localparam logic [2:0] DIV_mfhi = 3'b100;
  localparam logic [2:0] DIV_mflo = 3'b101;
  localparam logic [2:0] ALU_sub  = 3'b110;
  localparam logic [2:0] ALU_slt  = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;
  localparam logic [1:0] RES_SHF = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    MUL_RUN = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_seq.sv
// Multiply/divide sequencer: accepts div/mult, counts the unit latency,
// raises hilo_we on the last busy cycle and stalls HI/LO hazards.
module md_seq
  import alu_ctl_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic is_div,
  input  logic is_mult,
  input  logic is_hilo_rd,
  output logic div_start,
  output logic mul_start,
  output logic md_busy,
  output logic hilo_we,
  output logic stall
);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             md_done;
  logic             is_md;
  logic             accept;

  always_comb begin
    is_md   = is_div | is_mult;
    md_busy = (state_reg != IDLE);
    md_done = md_busy && (cnt_reg == '0);
    // Reset dominates: no pulse may escape in a cycle whose edge clears state.
    accept    = rst_n & valid_in & is_md & (!md_busy | md_done);
    div_start = accept & is_div;
    mul_start = accept & is_mult;
    hilo_we   = rst_n & md_done;
    // HI/LO readers wait through the done cycle; new ops may overlap it.
    stall = rst_n & valid_in &
            ((is_hilo_rd & md_busy) | (is_md & md_busy & !md_done));

    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      state_next = is_div ? DIV_RUN : MUL_RUN;
      cnt_next   = is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
    end else if (md_done) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (md_busy) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/alu_ctl_mc.sv
// EX-stage ALU control: combinational ALUOp/Funct decode plus the
// multi-cycle multiply/divide sequencer.
module alu_ctl_mc
  import alu_ctl_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  input  logic [4:0] shamt,
  output logic [2:0] alu_op,
  output logic [1:0] res_sel,
  output logic       div_start,
  output logic       mul_start,
  output logic       md_busy,
  output logic       hilo_we,
  output logic       stall,
  output logic       illegal
);

  logic dec_illegal;
  logic is_div, is_mult, is_hilo_rd;

  always_comb begin
    alu_op      = ALU_add;
    res_sel     = RES_ALU;
    dec_illegal = 1'b0;
    is_div      = 1'b0;
    is_mult     = 1'b0;
    is_hilo_rd  = 1'b0;
    case (ALUOp)
      AOP_ADD: alu_op = ALU_add;
      AOP_SUB: alu_op = ALU_sub;
      AOP_RTYPE: begin
        case (Funct)
          F_add: alu_op = ALU_add;
          F_sub: alu_op = ALU_sub;
          F_and: alu_op = ALU_and;
          F_or:  alu_op = ALU_or;
          F_slt: alu_op = ALU_slt;
          F_sll: begin
            // A zero-distance shift is the canonical nop; route it through the adder.
            if (shamt != 5'd0) begin
              alu_op  = ALU_sll;
              res_sel = RES_SHF;
            end
          end
          F_mfhi: begin
            alu_op     = DIV_mfhi;
            res_sel    = RES_HI;
            is_hilo_rd = 1'b1;
          end
          F_mflo: begin
            alu_op     = DIV_mflo;
            res_sel    = RES_LO;
            is_hilo_rd = 1'b1;
          end
          F_div:   is_div  = 1'b1;
          F_mult:  is_mult = 1'b1;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign illegal = valid_in & dec_illegal;

  md_seq #(
    .DIV_LATENCY(DIV_LATENCY),
    .MUL_LATENCY(MUL_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .is_div    (is_div),
    .is_mult   (is_mult),
    .is_hilo_rd(is_hilo_rd),
    .div_start (div_start),
    .mul_start (mul_start),
    .md_busy   (md_busy),
    .hilo_we   (hilo_we),
    .stall     (stall)
  );

endmodule

// File: tb/tb_alu_ctl_mc.sv
// Self-checking bench for alu_ctl_mc: directed scenarios plus random traffic
// checked every cycle against a timeline model of the mult/div unit.
module tb_alu_ctl_mc;

  localparam int DIV_L = 32;
  localparam int MUL_L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [4:0] shamt = 5'd0;
  logic [2:0] alu_op;
  logic [1:0] res_sel;
  logic       div_start, mul_start, md_busy, hilo_we, stall, illegal;

  alu_ctl_mc #(.DIV_LATENCY(DIV_L), .MUL_LATENCY(MUL_L), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp),
    .Funct(Funct), .shamt(shamt), .alu_op(alu_op), .res_sel(res_sel),
    .div_start(div_start), .mul_start(mul_start), .md_busy(md_busy),
    .hilo_we(hilo_we), .stall(stall), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int tcyc    = 0;

  // Model: the unit is busy from the cycle after acceptance for L cycles.
  bit active = 1'b0;
  int acc_cyc = 0;
  int acc_lat = 0;

  logic [5:0] funct_tab [12] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0,
                                 6'd16, 6'd18, 6'd25, 6'd25, 6'd27, 6'd5};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, tcyc, got, exp);
    end
  endtask

  function automatic void decode(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                 output int a, output int r, output bit ill,
                                 output bit dv, output bit ml, output bit rd);
    a = 2; r = 0; ill = 0; dv = 0; ml = 0; rd = 0;
    if (op == 2'd1) a = 6;
    else if (op == 2'd3) ill = 1;
    else if (op == 2'd2) begin
      case (int'(f))
        32: a = 2;
        34: a = 6;
        36: a = 0;
        37: a = 1;
        42: a = 7;
        0:  if (sh != 0) begin a = 3; r = 3; end
        16: begin a = 4; r = 1; rd = 1; end
        18: begin a = 5; r = 2; rd = 1; end
        27: dv = 1;
        25: ml = 1;
        default: ill = 1;
      endcase
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [1:0] op,
                      input logic [5:0] f, input logic [4:0] sh);
    int  ea, er;
    bit  ill, dv, ml, rd, busy, done, acc;
    @(posedge clk);
    #1;
    rst_n = r; valid_in = v; ALUOp = op; Funct = f; shamt = sh;
    @(negedge clk);
    decode(op, f, sh, ea, er, ill, dv, ml, rd);
    busy = active && (tcyc > acc_cyc) && (tcyc <= acc_cyc + acc_lat);
    done = busy && (tcyc == acc_cyc + acc_lat);
    acc  = r && v && (dv || ml) && (!busy || done);
    check_val("alu_op",    8'(alu_op),    8'(ea));
    check_val("res_sel",   8'(res_sel),   8'(er));
    check_val("illegal",   8'(illegal),   8'(v && ill));
    check_val("div_start", 8'(div_start), 8'(acc && dv));
    check_val("mul_start", 8'(mul_start), 8'(acc && ml));
    check_val("md_busy",   8'(md_busy),   8'(busy));
    check_val("hilo_we",   8'(hilo_we),   8'(r && done));
    check_val("stall",     8'(stall),     8'(r && v && ((rd && busy) || ((dv || ml) && busy && !done))));
    if (!r) begin
      active = 1'b0;
    end else if (acc) begin
      active  = 1'b1;
      acc_cyc = tcyc;
      acc_lat = dv ? DIV_L : MUL_L;
      $display("cycle %0d: %s accepted", tcyc, dv ? "div" : "mult");
    end
    tcyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'b00, 6'd0, 5'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // Reset state while held in reset, including with a div presented.
    step(0, 0, 2'b00, 6'd0, 5'd0);
    step(0, 1, 2'b10, 6'd27, 5'd0);
    // Decode sweep.
    step(1, 1, 2'b00, 6'd0, 5'd0);
    step(1, 1, 2'b01, 6'd0, 5'd0);
    step(1, 1, 2'b11, 6'd32, 5'd0);
    for (int i = 0; i < 12; i++) step(1, 1, 2'b10, funct_tab[i], 5'd3);
    step(1, 1, 2'b10, 6'd0, 5'd0);
    step(1, 0, 2'b10, 6'd5, 5'd0);
    idle(MUL_L + 2);
    // Divide, then mfhi presented until it gets through; add issued while busy.
    step(1, 1, 2'b10, 6'd27, 5'd0);
    idle(4);
    step(1, 1, 2'b10, 6'd32, 5'd0);
    idle(4);
    for (int i = 0; i < DIV_L; i++) step(1, 1, 2'b10, 6'd16, 5'd0);
    idle(2);
    // Back-to-back multiplies.
    step(1, 1, 2'b10, 6'd25, 5'd0);
    step(1, 0, 2'b00, 6'd0, 5'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 2'b10, 6'd25, 5'd0);
    idle(MUL_L + 2);
    // Reset mid-divide, then an immediate new divide.
    step(1, 1, 2'b10, 6'd27, 5'd0);
    idle(14);
    step(0, 0, 2'b00, 6'd0, 5'd0);
    step(1, 1, 2'b10, 6'd27, 5'd0);
    idle(DIV_L + 2);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit          r, v;
      logic [1:0]  op;
      logic [5:0]  f;
      logic [4:0]  sh;
      r  = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 11)];
      if (f == 6'd27 && $urandom_range(0, 3) != 0) f = 6'd25;
      sh = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      step(r, v, op, f, sh);
    end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
